// File: rtl/turf_header_framer.sv
// TURF header framer: splits the 64-bit header qword stream into fixed-size frames.
// Checks the qword-0 and trailer signatures and event-number continuity; emits AXI4-Stream with tlast/tuser.
module turf_header_framer #(
  parameter int unsigned FRAME_QWORDS = 16,
  parameter logic [15:0] HEADER_WORDS = 16'h003F,
  parameter logic [15:0] EVENT_FORMAT = 16'h4531,
  parameter logic [15:0] SURF_WORDS   = 16'h0040
) (
  input  logic        memclk,
  input  logic        memrst,
  input  logic [63:0] s_thdr_tdata,
  input  logic        s_thdr_tvalid,
  output logic        s_thdr_tready,
  output logic [63:0] m_hdr_tdata,
  output logic        m_hdr_tvalid,
  input  logic        m_hdr_tready,
  output logic        m_hdr_tlast,
  output logic [1:0]  m_hdr_tuser,
  output logic        in_sync_o,
  output logic [31:0] frame_count_o,
  output logic [15:0] err_count_o,
  output logic        seq_err_o
);

  localparam int unsigned BW = (FRAME_QWORDS > 2) ? $clog2(FRAME_QWORDS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(FRAME_QWORDS - 1);

  typedef enum logic {HUNT, PASS} state_t;

  state_t        state;
  logic [BW-1:0] beat;
  logic          first_frame;
  logic          seq_pend;
  logic [31:0]   last_event;

  logic        out_free;
  logic        accept;
  logic        sig_ok;
  logic        seq_break;
  logic        trailer_bad;
  logic        is_last;
  logic [31:0] in_event;
  logic [1:0]  err_inc;
  logic [16:0] err_sum;

  // HUNT also waits for a free output register, so a stalled beat is never
  // overwritten; once the last frame drains this is the constant 1 of HUNT.
  assign out_free      = !m_hdr_tvalid || m_hdr_tready;
  assign s_thdr_tready = out_free;
  assign accept        = s_thdr_tvalid && s_thdr_tready;

  assign in_event    = s_thdr_tdata[63:32];
  assign sig_ok      = (s_thdr_tdata[15:0] == HEADER_WORDS) &&
                       (s_thdr_tdata[31:16] == EVENT_FORMAT);
  assign trailer_bad = (s_thdr_tdata[63:48] != SURF_WORDS);
  assign is_last     = (beat == LAST_BEAT);
  assign seq_break   = !first_frame && (in_event != last_event + 32'd1) &&
                       (in_event != '0);

  always_comb begin
    err_inc = '0;
    if (accept && state == PASS) begin
      if (beat == '0) begin
        if (!sig_ok || seq_break) err_inc = 2'd1;
      end else if (is_last && trailer_bad) begin
        err_inc = 2'd1;
      end
    end
  end

  assign err_sum = {1'b0, err_count_o} + {15'd0, err_inc};

  always_ff @(posedge memclk or posedge memrst) begin
    if (memrst) begin
      state         <= HUNT;
      beat          <= '0;
      first_frame   <= 1'b1;
      seq_pend      <= 1'b0;
      last_event    <= '0;
      m_hdr_tdata   <= '0;
      m_hdr_tvalid  <= 1'b0;
      m_hdr_tlast   <= 1'b0;
      m_hdr_tuser   <= '0;
      in_sync_o     <= 1'b0;
      frame_count_o <= '0;
      err_count_o   <= '0;
      seq_err_o     <= 1'b0;
    end else begin
      seq_err_o   <= 1'b0;
      err_count_o <= err_sum[16] ? '1 : err_sum[15:0];

      if (m_hdr_tvalid && m_hdr_tready) begin
        m_hdr_tvalid <= 1'b0;
        if (m_hdr_tlast) frame_count_o <= frame_count_o + 32'd1;
      end

      if (accept) begin
        case (state)
          HUNT: begin
            if (sig_ok) begin
              m_hdr_tvalid <= 1'b1;
              m_hdr_tdata  <= s_thdr_tdata;
              m_hdr_tlast  <= 1'b0;
              m_hdr_tuser  <= '0;
              state        <= PASS;
              in_sync_o    <= 1'b1;
              beat         <= BW'(1);
              last_event   <= in_event;
              first_frame  <= 1'b0;
              seq_pend     <= 1'b0;
            end
          end
          PASS: begin
            if (beat == '0) begin
              if (!sig_ok) begin
                state       <= HUNT;
                in_sync_o   <= 1'b0;
                first_frame <= 1'b1;
              end else begin
                m_hdr_tvalid <= 1'b1;
                m_hdr_tdata  <= s_thdr_tdata;
                m_hdr_tlast  <= 1'b0;
                m_hdr_tuser  <= '0;
                beat         <= BW'(1);
                last_event   <= in_event;
                first_frame  <= 1'b0;
                seq_pend     <= seq_break;
                seq_err_o    <= seq_break;
              end
            end else begin
              m_hdr_tvalid <= 1'b1;
              m_hdr_tdata  <= s_thdr_tdata;
              m_hdr_tlast  <= is_last;
              m_hdr_tuser  <= is_last ? {seq_pend, trailer_bad} : 2'b00;
              beat         <= is_last ? '0 : beat + BW'(1);
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_turf_header_framer.sv
// Directed bench for turf_header_framer: framing, signature/sequence errors, relock,
// random backpressure and mid-frame reset.
module tb_turf_header_framer;

  logic        memclk;
  logic        memrst;
  logic [63:0] s_thdr_tdata;
  logic        s_thdr_tvalid;
  logic        s_thdr_tready;
  logic [63:0] m_hdr_tdata;
  logic        m_hdr_tvalid;
  logic        m_hdr_tready;
  logic        m_hdr_tlast;
  logic [1:0]  m_hdr_tuser;
  logic        in_sync_o;
  logic [31:0] frame_count_o;
  logic [15:0] err_count_o;
  logic        seq_err_o;

  int unsigned n_tests;
  int unsigned n_fail;

  logic [63:0] stim [128];
  int unsigned p_i, p_cyc, c_idx, c_cyc;
  logic        c_stalled;
  logic [63:0] c_hd;
  logic        c_hl;
  logic [1:0]  c_hu;

  turf_header_framer #(
    .FRAME_QWORDS(16),
    .HEADER_WORDS(16'h003F),
    .EVENT_FORMAT(16'h4531),
    .SURF_WORDS  (16'h0040)
  ) dut (
    .memclk       (memclk),
    .memrst       (memrst),
    .s_thdr_tdata (s_thdr_tdata),
    .s_thdr_tvalid(s_thdr_tvalid),
    .s_thdr_tready(s_thdr_tready),
    .m_hdr_tdata  (m_hdr_tdata),
    .m_hdr_tvalid (m_hdr_tvalid),
    .m_hdr_tready (m_hdr_tready),
    .m_hdr_tlast  (m_hdr_tlast),
    .m_hdr_tuser  (m_hdr_tuser),
    .in_sync_o    (in_sync_o),
    .frame_count_o(frame_count_o),
    .err_count_o  (err_count_o),
    .seq_err_o    (seq_err_o)
  );

  initial begin
    memclk = 1'b0;
    forever #5 memclk = ~memclk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Qword k of a frame for event ev; the trailer carries trl in [63:48].
  function automatic logic [63:0] mk(input logic [31:0] ev, input int unsigned k,
                                     input logic [15:0] trl);
    logic [15:0] kk;
    kk = 16'(k);
    if (k == 0)  return {ev, 16'h4531, 16'h003F};
    if (k == 15) return {trl, ev[15:0], 16'h0000, kk};
    return {ev, kk, kk};
  endfunction

  task automatic do_reset;
    @(negedge memclk);
    memrst = 1'b1;
    s_thdr_tvalid = 1'b0;
    #1;
    chk("rst_valid", m_hdr_tvalid, 1'b0);
    chk("rst_data", m_hdr_tdata, 64'd0);
    chk("rst_last", m_hdr_tlast, 1'b0);
    chk("rst_user", m_hdr_tuser, 2'd0);
    chk("rst_sync", in_sync_o, 1'b0);
    chk("rst_fcnt", frame_count_o, 32'd0);
    chk("rst_ecnt", err_count_o, 16'd0);
    chk("rst_seq", seq_err_o, 1'b0);
    @(negedge memclk);
    memrst = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] ev, input logic [15:0] trl,
                            input logic [1:0] exp_user, input logic exp_seq);
    logic [63:0] d;
    for (int k = 0; k < 16; k++) begin
      @(negedge memclk);
      d = mk(ev, k, trl);
      s_thdr_tvalid = 1'b1;
      s_thdr_tdata  = d;
      @(posedge memclk);
      #1;
      chk("out_valid", m_hdr_tvalid, 1'b1);
      chk("out_data", m_hdr_tdata, d);
      chk("out_last", m_hdr_tlast, k == 15);
      chk("out_user", m_hdr_tuser, (k == 15) ? exp_user : 2'b00);
      if (k == 0) begin
        chk("sync_on_beat0", in_sync_o, 1'b1);
        chk("seq_pulse", seq_err_o, exp_seq);
      end
    end
  endtask

  task automatic drop(input logic [63:0] d);
    @(negedge memclk);
    s_thdr_tvalid = 1'b1;
    s_thdr_tdata  = d;
    #1;
    chk("drop_ready", s_thdr_tready, 1'b1);
    @(posedge memclk);
    #1;
    chk("drop_valid", m_hdr_tvalid, 1'b0);
  endtask

  task automatic idle;
    @(negedge memclk);
    s_thdr_tvalid = 1'b0;
    @(posedge memclk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    memrst = 1'b1;
    s_thdr_tvalid = 1'b0;
    s_thdr_tdata  = '0;
    m_hdr_tready  = 1'b1;

    // 1: two clean frames at full rate
    do_reset();
    send_frame(32'd5, 16'h0040, 2'b00, 1'b0);
    send_frame(32'd6, 16'h0040, 2'b00, 1'b0);
    idle();
    chk("t1_fcnt", frame_count_o, 32'd2);
    chk("t1_ecnt", err_count_o, 16'd0);

    // 2: junk while hunting, then first frame (no sequence check)
    do_reset();
    for (int j = 0; j < 3; j++) drop(64'hDEADBEEF_00000000);
    chk("t2_hunt_sync", in_sync_o, 1'b0);
    send_frame(32'd9, 16'h0040, 2'b00, 1'b0);
    idle();
    chk("t2_fcnt", frame_count_o, 32'd1);
    chk("t2_ecnt", err_count_o, 16'd0);

    // 3: sequence break on 13, event 0 always accepted
    send_frame(32'd10, 16'h0040, 2'b00, 1'b0);
    send_frame(32'd11, 16'h0040, 2'b00, 1'b0);
    send_frame(32'd13, 16'h0040, 2'b10, 1'b1);
    send_frame(32'd0,  16'h0040, 2'b00, 1'b0);
    idle();
    chk("t3_ecnt", err_count_o, 16'd1);
    chk("t3_fcnt", frame_count_o, 32'd5);

    // 4: bad trailer
    send_frame(32'd1, 16'h0041, 2'b01, 1'b0);
    idle();
    chk("t4_ecnt", err_count_o, 16'd2);
    chk("t4_fcnt", frame_count_o, 32'd6);

    // 5: bad qword 0 drops to HUNT, rest of frame dropped, relock without sequence check
    send_frame(32'd2, 16'h0040, 2'b00, 1'b0);
    drop({32'd3, 16'h4532, 16'h003F});
    chk("t5_sync_lost", in_sync_o, 1'b0);
    chk("t5_ecnt", err_count_o, 16'd3);
    for (int k = 1; k < 16; k++) drop(mk(32'd3, k, 16'h0040));
    send_frame(32'd50, 16'h0040, 2'b00, 1'b0);
    idle();
    chk("t5_fcnt", frame_count_o, 32'd8);
    chk("t5_ecnt_relock", err_count_o, 16'd3);

    // 6: random backpressure over 8 frames
    for (int f = 0; f < 8; f++)
      for (int k = 0; k < 16; k++)
        stim[f*16 + k] = mk(32'd51 + 32'(f), k, 16'h0040);
    p_i = 0; p_cyc = 0; c_idx = 0; c_cyc = 0;
    c_stalled = 1'b0; c_hd = '0; c_hl = 1'b0; c_hu = '0;
    s_thdr_tvalid = 1'b1;
    s_thdr_tdata  = stim[0];
    fork
      begin
        while (p_i < 128 && p_cyc < 4000) begin
          @(negedge memclk);
          #2;
          p_cyc++;
          if (s_thdr_tready) begin
            @(posedge memclk);
            #1;
            p_i++;
            if (p_i < 128) s_thdr_tdata = stim[p_i];
            else s_thdr_tvalid = 1'b0;
          end
        end
        s_thdr_tvalid = 1'b0;
      end
      begin
        while (c_idx < 128 && c_cyc < 4000) begin
          @(negedge memclk);
          c_cyc++;
          if (c_stalled) begin
            chk("stall_valid", m_hdr_tvalid, 1'b1);
            chk("stall_data", m_hdr_tdata, c_hd);
            chk("stall_last", m_hdr_tlast, c_hl);
            chk("stall_user", m_hdr_tuser, c_hu);
          end
          m_hdr_tready = ($urandom_range(0, 1) == 1);
          c_stalled = m_hdr_tvalid && !m_hdr_tready;
          c_hd = m_hdr_tdata;
          c_hl = m_hdr_tlast;
          c_hu = m_hdr_tuser;
          if (m_hdr_tvalid && m_hdr_tready) begin
            chk("rand_data", m_hdr_tdata, stim[c_idx]);
            chk("rand_last", m_hdr_tlast, (c_idx % 16) == 15);
            chk("rand_user", m_hdr_tuser, 2'b00);
            c_idx++;
          end
        end
      end
    join
    chk("rand_beats_in", p_i, 128);
    chk("rand_beats_out", c_idx, 128);
    @(negedge memclk);
    m_hdr_tready = 1'b1;
    repeat (3) @(posedge memclk);
    #1;
    chk("t6_fcnt", frame_count_o, 32'd16);
    chk("t6_ecnt", err_count_o, 16'd3);

    // 6b: reset asserted on beat 7 of a frame
    for (int k = 0; k < 8; k++) begin
      @(negedge memclk);
      s_thdr_tvalid = 1'b1;
      s_thdr_tdata  = mk(32'd60, k, 16'h0040);
      @(posedge memclk);
      #1;
    end
    chk("mid_valid_before", m_hdr_tvalid, 1'b1);
    memrst = 1'b1;
    #1;
    chk("mid_rst_valid", m_hdr_tvalid, 1'b0);
    chk("mid_rst_data", m_hdr_tdata, 64'd0);
    chk("mid_rst_last", m_hdr_tlast, 1'b0);
    chk("mid_rst_sync", in_sync_o, 1'b0);
    chk("mid_rst_fcnt", frame_count_o, 32'd0);
    chk("mid_rst_ecnt", err_count_o, 16'd0);
    @(negedge memclk);
    memrst = 1'b0;
    drop(mk(32'd60, 8, 16'h0040));
    chk("mid_hunt_sync", in_sync_o, 1'b0);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
